// File: rtl/stopwatch_pkg.sv
// Shared state encoding for the stopwatch controller.
package stopwatch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } sw_state_e;

  // Prescaler advances only while time is actually elapsing.
  function automatic logic is_counting(input sw_state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop button synchronizer with single-cycle rising-edge press detect.
module btn_edge (
  input  logic clk,
  input  logic nrst,
  input  logic btn,
  output logic press
);

  logic [1:0] sync_pipe;
  logic [1:0] rdy_pipe;
  logic       prev;
  logic       armed;

  // armed only sets once a genuinely synchronized low has been seen, so a
  // button already held when reset releases never counts as a press.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_pipe <= '0;
      rdy_pipe  <= '0;
      prev      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], btn};
      rdy_pipe  <= {rdy_pipe[0], 1'b1};
      prev      <= sync_pipe[1];
      if (rdy_pipe[1] && !sync_pipe[1])
        armed <= 1'b1;
    end
  end

  assign press = sync_pipe[1] & ~prev & armed;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with tick prescaler; drives counter enable/clear and
// the lap display freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV = 10000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_hold,
  output logic [1:0] state_out
);

  localparam int            PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(DIV - 1);

  sw_state_e     state, nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          ss_press, lr_press;
  logic          clr_nxt, tick;

  btn_edge u_ss (.clk(clk), .nrst(nrst), .btn(btn_ss), .press(ss_press));
  btn_edge u_lr (.clk(clk), .nrst(nrst), .btn(btn_lr), .press(lr_press));

  // ss is checked first everywhere, so a coincident lr press is dropped.
  always_comb begin
    nxt     = state;
    clr_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_press)      nxt = ST_RUN;
        else if (lr_press) clr_nxt = 1'b1;
      end
      ST_RUN: begin
        if (ss_press)      nxt = ST_PAUSE;
        else if (lr_press) nxt = ST_LAP;
      end
      ST_LAP: begin
        if (ss_press)      nxt = ST_PAUSE;
        else if (lr_press) nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (ss_press) nxt = ST_RUN;
        else if (lr_press) begin
          nxt     = ST_IDLE;
          clr_nxt = 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Counting follows the current state, so a tick due on a RUN->PAUSE edge
  // still fires and the held remainder resumes intact.
  always_comb begin
    presc_nxt = presc;
    tick      = is_counting(state) && (presc == PS_MAX);
    if (nxt == ST_IDLE)
      presc_nxt = '0;
    else if (is_counting(state))
      presc_nxt = (presc == PS_MAX) ? '0 : presc + PW'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      presc     <= '0;
      count_en  <= 1'b0;
      count_clr <= 1'b0;
      lap_hold  <= 1'b0;
    end else begin
      state     <= nxt;
      presc     <= presc_nxt;
      count_en  <= tick;
      count_clr <= clr_nxt;
      lap_hold  <= (nxt == ST_LAP);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at DIV=4 with hand-computed tick timing.
module tb_stopwatch_ctrl;

  logic       clk, nrst, btn_ss, btn_lr;
  logic       count_en, count_clr, lap_hold;
  logic [1:0] state_out;
  int         n_chk, n_err;

  stopwatch_ctrl #(.DIV(4)) dut (
    .clk(clk), .nrst(nrst), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .count_en(count_en), .count_clr(count_clr),
    .lap_hold(lap_hold), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n ticks; bit i of pat is the expected count_en after tick i+1
  task automatic run_ce(input string tag, input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, 32'(count_en), 32'(pat[i]));
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    nrst = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0;
    repeat (3) tick();
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_ce",    32'(count_en),  32'd0);
    chk("rst_clr",   32'(count_clr), 32'd0);
    chk("rst_lap",   32'(lap_hold),  32'd0);

    nrst = 1'b1;
    run_ce("idle_ce", 3, 16'h0);

    // start: state changes on the 3rd edge
    btn_ss = 1'b1;
    tick(); tick();
    chk("ss_lat2", 32'(state_out), 32'd0);
    tick();
    chk("ss_run", 32'(state_out), 32'd1);
    btn_ss = 1'b0;
    run_ce("run_first", 7, 16'b0001000);

    // pause with prescaler left at 2
    btn_ss = 1'b1;
    run_ce("run_2nd", 2, 16'b01);
    tick();
    chk("pause_st", 32'(state_out), 32'd3);
    chk("pause_ce", 32'(count_en), 32'd0);
    btn_ss = 1'b0;
    run_ce("pause_hold", 6, 16'h0);
    chk("pause_st2", 32'(state_out), 32'd3);

    // resume: remaining two cycles then tick
    btn_ss = 1'b1;
    run_ce("resume_pre", 2, 16'h0);
    tick();
    chk("resume_st", 32'(state_out), 32'd1);
    chk("resume_ce0", 32'(count_en), 32'd0);
    btn_ss = 1'b0;
    run_ce("resume_ce1", 1, 16'h0);
    run_ce("resume_ce2", 1, 16'h1);
    run_ce("resume_run", 3, 16'h0);

    // lap
    btn_lr = 1'b1;
    run_ce("lap_pre", 3, 16'b001);
    chk("lap_st",   32'(state_out), 32'd2);
    chk("lap_hold", 32'(lap_hold),  32'd1);
    btn_lr = 1'b0;
    run_ce("lap_ce", 8, 16'b00100010);
    chk("lap_st2", 32'(state_out), 32'd2);
    btn_lr = 1'b1;
    run_ce("unlap_pre", 3, 16'b010);
    chk("unlap_st",  32'(state_out), 32'd1);
    chk("unlap_lap", 32'(lap_hold),  32'd0);
    btn_lr = 1'b0;
    run_ce("unlap_run", 3, 16'b100);

    // simultaneous presses act as ss only
    btn_ss = 1'b1; btn_lr = 1'b1;
    run_ce("both_pre", 3, 16'h0);
    chk("both_st",  32'(state_out), 32'd3);
    chk("both_lap", 32'(lap_hold),  32'd0);
    chk("both_clr", 32'(count_clr), 32'd0);
    btn_ss = 1'b0; btn_lr = 1'b0;
    run_ce("both_pause", 4, 16'h0);

    // PAUSE -> IDLE with clear
    btn_lr = 1'b1;
    tick(); tick(); tick();
    chk("clr_st",  32'(state_out), 32'd0);
    chk("clr_on",  32'(count_clr), 32'd1);
    tick();
    chk("clr_off", 32'(count_clr), 32'd0);
    btn_lr = 1'b0;
    repeat (3) tick();

    // lr in IDLE clears again
    btn_lr = 1'b1;
    tick(); tick(); tick();
    chk("iclr_st", 32'(state_out), 32'd0);
    chk("iclr_on", 32'(count_clr), 32'd1);
    tick();
    chk("iclr_off", 32'(count_clr), 32'd0);
    btn_lr = 1'b0;
    repeat (3) tick();

    // reset mid-RUN with ss held through release
    btn_ss = 1'b1;
    tick(); tick(); tick();
    chk("run2_st", 32'(state_out), 32'd1);
    btn_ss = 1'b0;
    run_ce("run2_ce", 2, 16'h0);
    #2 nrst = 1'b0;
    btn_ss = 1'b1;
    #1;
    chk("arst_st", 32'(state_out), 32'd0);
    tick(); tick();
    nrst = 1'b1;
    run_ce("post_rst_ce", 8, 16'h0);
    chk("held_st", 32'(state_out), 32'd0);
    btn_ss = 1'b0;
    repeat (3) tick();
    btn_ss = 1'b1;
    tick(); tick(); tick();
    chk("repress_st", 32'(state_out), 32'd1);
    btn_ss = 1'b0;
    run_ce("repress_ce", 4, 16'b1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 10000 (>=2): clk cycles per counting tick.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port btn_ss  input  1  start/stop button, asynchronous level, active-high.
REQ-005 SHALL have port btn_lr  input  1  lap/reset button, asynchronous level, active-high.
REQ-006 SHALL have port count_en  output  1  one-cycle strobe advancing the time counter by one second.
REQ-007 SHALL have port count_clr  output  1  one-cycle strobe zeroing the time counter.
REQ-008 SHALL have port lap_hold  output  1  high = display frozen, counter keeps running.
REQ-009 SHALL have port state_out  output  2  current FSM state encoding.

Function
REQ-010 Each button SHALL pass a two-flop synchronizer; a press SHALL be a rising edge of the synchronized level, valid for exactly one cycle per press.
REQ-011 Press-to-effect latency: the state register SHALL update on the 3rd rising clk edge after the first edge sampling the button high.
REQ-012 Held buttons SHALL produce one press only; re-press requires the level low for at least one synchronized cycle.
REQ-013 States: IDLE=0, RUN=1, LAP=2, PAUSE=3.
REQ-014 IDLE: ss press -> RUN; lr press -> stay IDLE, count_clr pulse.
REQ-015 RUN: ss press -> PAUSE; lr press -> LAP.
REQ-016 LAP: lr press -> RUN; ss press -> PAUSE.
REQ-017 PAUSE: ss press -> RUN; lr press -> IDLE, count_clr pulse.
REQ-018 Simultaneous ss and lr presses in one cycle SHALL act as ss only; the lr press is discarded.
REQ-019 The prescaler, width clog2(DIV), SHALL count 0..DIV-1 in RUN and LAP, wrap to 0 after DIV-1, hold in PAUSE, and be 0 in IDLE.
REQ-020 count_en SHALL be high for one cycle when the prescaler is at DIV-1 in RUN or LAP; the period is exactly DIV cycles.
REQ-021 The first count_en after IDLE->RUN SHALL occur DIV cycles after the transition edge.
REQ-022 PAUSE->RUN SHALL resume from the held prescaler value, with no tick lost or duplicated.
REQ-023 count_clr SHALL be registered, asserted in the cycle following the transition edge, and never coincide with count_en.
REQ-024 lap_hold SHALL be high if and only if the state is LAP; count_en SHALL continue during LAP.
REQ-025 All outputs SHALL be driven from flops, with no combinational path from the buttons.

Reset
REQ-026 nrst low SHALL asynchronously force: state IDLE, prescaler 0, synchronizer and edge flops 0, count_en 0, count_clr 0, lap_hold 0, state_out 0.
REQ-027 A button held high through reset release SHALL NOT generate a press.
REQ-028 Reset mid-RUN SHALL abort any pending tick; no count_en within DIV cycles after release.

Structure
REQ-029 Package stopwatch_pkg SHALL hold the state enum (2-bit) and state encodings.
REQ-030 Sub-module btn_edge SHALL implement the synchronizer and rising-edge detect; instantiated twice.
REQ-031 The FSM and prescaler SHALL reside in stopwatch_ctrl; DIV SHALL be the only parameter.

Verification (DIV=4)
REQ-032 Reset, ss press -> RUN after 3 edges; count_en every 4th cycle, first 4 cycles after transition.
REQ-033 RUN, ss press at prescaler=2 -> PAUSE, no count_en; ss press -> count_en exactly 2 cycles after re-entering RUN.
REQ-034 RUN, lr press -> LAP, lap_hold=1, count_en continues every 4 cycles; lr press -> RUN, lap_hold=0.
REQ-035 PAUSE, lr press -> IDLE, single count_clr pulse, state_out=0; lr in IDLE -> another count_clr pulse.
REQ-036 ss and lr rising on the same cycle in RUN -> PAUSE, lap_hold stays 0.
REQ-037 btn_ss held high across nrst release -> state stays IDLE until the button is released and pressed again.
